cacheline_adaptor: RTL and testbench

- Sits directly downstream of the direct-mapped cache datapath, between the cache's 256-bit line port and the 64-bit burst physical-memory interface.
- Converts one cache line read into 4 memory beats assembled into a line, and one line write into 4 memory beats.
- Generates a single-cycle completion pulse back to the cache controller.

---
 rtl/cacheline_adaptor_pkg.sv | 8 +
 rtl/cacheline_adaptor.sv | 117 +++++++++++
 tb/tb_cacheline_adaptor.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cacheline_adaptor_pkg.sv
// cacheline_adaptor_pkg: state encoding and size constants shared by the line/burst adaptor.
package cacheline_adaptor_pkg;
    localparam int LINE_WIDTH_DEF  = 256;
    localparam int BURST_WIDTH_DEF = 64;
    localparam int BEATS           = 4;
    localparam int BEAT_IDX_W      = 2;
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
endpackage

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: converts 256-bit cache line reads/writes into 4-beat 64-bit memory bursts.
// Optional watchdog enabled by defining CACHELINE_ADAPTOR_TIMEOUT_EN.
module cacheline_adaptor
    import cacheline_adaptor_pkg::*;
#(
    parameter int LINE_WIDTH     = LINE_WIDTH_DEF,
    parameter int BURST_WIDTH    = BURST_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LINE_WIDTH-1:0]  line_i,
    output logic [LINE_WIDTH-1:0]  line_o,
    input  logic [31:0]            address_i,
    input  logic                   read_i,
    input  logic                   write_i,
    output logic                   resp_o,
    input  logic [BURST_WIDTH-1:0] burst_i,
    output logic [BURST_WIDTH-1:0] burst_o,
    output logic [31:0]            address_o,
    output logic                   read_o,
    output logic                   write_o,
    input  logic                   resp_i,
    output logic                   error_o
);
    localparam logic [31:0] LINE_MASK = ~32'((LINE_WIDTH / 8) - 1);

    state_t                r_state;
    logic [BEAT_IDX_W-1:0] r_cnt;
    logic [LINE_WIDTH-1:0] r_buf;
    logic [31:0]           r_addr;
    logic                  r_read;
    logic                  r_write;
    logic                  r_resp;
    logic                  w_last;
    logic                  w_tmo;

    assign w_last = resp_i && r_cnt == BEAT_IDX_W'(BEATS - 1);

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] r_wd;
    logic            r_err;

    assign w_tmo   = !resp_i && r_wd == WD_W'(TIMEOUT_CYCLES - 1);
    assign error_o = r_err;

    // Watchdog is zero on every entry to READ/WRITE because it is held clear outside them.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_wd  <= '0;
            r_err <= 1'b0;
        end else begin
            r_wd  <= ((r_state == READ || r_state == WRITE) && !resp_i) ? r_wd + 1'b1 : '0;
            r_err <= (r_state == READ || r_state == WRITE) && w_tmo;
        end
`else
    assign w_tmo   = 1'b0;
    assign error_o = 1'b0;
`endif

    assign line_o    = r_buf;
    assign address_o = r_addr;
    assign read_o    = r_read;
    assign write_o   = r_write;
    assign resp_o    = r_resp;
    assign burst_o   = r_buf[r_cnt * BURST_WIDTH +: BURST_WIDTH];

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_buf   <= '0;
            r_addr  <= '0;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_resp  <= 1'b0;
        end else begin
            r_resp <= 1'b0;
            case (r_state)
                IDLE:
                    if (write_i) begin
                        r_state <= WRITE;
                        r_write <= 1'b1;
                        r_buf   <= line_i;
                        r_addr  <= address_i & LINE_MASK;
                        r_cnt   <= '0;
                    end else if (read_i) begin
                        r_state <= READ;
                        r_read  <= 1'b1;
                        r_addr  <= address_i & LINE_MASK;
                        r_cnt   <= '0;
                    end
                READ: begin
                    if (resp_i) begin
                        r_buf[r_cnt * BURST_WIDTH +: BURST_WIDTH] <= burst_i;
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (w_last || w_tmo) begin
                        r_state <= DONE;
                        r_read  <= 1'b0;
                        r_resp  <= 1'b1;
                    end
                end
                WRITE: begin
                    if (resp_i)
                        r_cnt <= r_cnt + 1'b1;
                    if (w_last || w_tmo) begin
                        r_state <= DONE;
                        r_write <= 1'b0;
                        r_resp  <= 1'b1;
                    end
                end
                DONE: r_state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb_cacheline_adaptor: randomized scoreboard bench with a behavioural memory model for cacheline_adaptor.
module tb_cacheline_adaptor;
    localparam int LW = 256;
    localparam int BW = 64;

    typedef struct {
        bit             is_wr;
        logic [31:0]    addr;
        logic [LW-1:0]  line;
        int             lat;
        bit             err;
        int             req_cyc;
    } txn_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [LW-1:0] line_i = '0;
    logic [LW-1:0] line_o;
    logic [31:0]   address_i = '0;
    logic [31:0]   address_o;
    logic          read_i = 1'b0;
    logic          write_i = 1'b0;
    logic          resp_o;
    logic [BW-1:0] burst_i = '0;
    logic [BW-1:0] burst_o;
    logic          read_o;
    logic          write_o;
    logic          resp_i = 1'b0;
    logic          error_o;

    cacheline_adaptor #(.LINE_WIDTH(LW), .BURST_WIDTH(BW), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .line_i(line_i), .line_o(line_o), .address_i(address_i),
        .read_i(read_i), .write_i(write_i), .resp_o(resp_o), .burst_i(burst_i), .burst_o(burst_o),
        .address_o(address_o), .read_o(read_o), .write_o(write_o), .resp_i(resp_i), .error_o(error_o)
    );

    always #5 clk = ~clk;

    txn_t          q[$];
    logic [BW-1:0] rd_beats[$];
    logic [BW-1:0] beat_pat[$];
    bit            resp_pat[$];
    logic [LW-1:0] last_line = '0;
    logic [LW-1:0] mline;
    logic [LW-1:0] mexp;
    txn_t          mt;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            acc = 0;
    int            stall = 0;
    int            strobe_cyc = 0;
    bit            idle_resp = 1'b0;
    bit            mr;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [LW-1:0] rnd_line();
        logic [LW-1:0] l;
        for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic set_pat(input logic [15:0] p, input int n);
        for (int i = n - 1; i >= 0; i--) resp_pat.push_back(p[i]);
    endtask

    // Memory model: answers strobes with beats and checks what the adaptor presents each beat.
    always @(negedge clk) begin
        if (rst) begin
            resp_i = 1'b0;
        end else if (read_o || write_o) begin
            strobe_cyc++;
            if (q.size() == 0) begin
                chk("strobe_without_request", 1, 0);
            end else begin
                mline = q[0].line;
                chk("strobe_kind", {read_o, write_o}, q[0].is_wr ? 2'b01 : 2'b10);
                chk("address_o", address_o, q[0].addr);
                if (write_o) chk("burst_o", burst_o, mline[acc*BW +: BW]);
            end
            mr = resp_pat.size() != 0 ? resp_pat.pop_front() : (stall >= 4 || $urandom_range(3) != 0);
            stall = mr ? 0 : stall + 1;
            resp_i = mr;
            if (mr) begin
                acc++;
                if (read_o) begin
                    burst_i = beat_pat.size() != 0 ? beat_pat.pop_front() : {$urandom, $urandom};
                    rd_beats.push_back(burst_i);
                end
            end
        end else begin
            stall = 0;
            resp_i = idle_resp;
            burst_i = {$urandom, $urandom};
        end
    end

    // Monitor: pops the scoreboard on every completion pulse.
    always @(negedge clk) begin
        if (!rst && !resp_o) chk("error_without_resp", error_o, 0);
        if (!rst && resp_o) begin
            if (q.size() == 0) begin
                chk("unexpected_resp_o", 1, 0);
            end else begin
                mt = q.pop_front();
                mexp = last_line;
                if (mt.is_wr) mexp = mt.line;
                else foreach (rd_beats[i]) if (i < 4) mexp[i*BW +: BW] = rd_beats[i];
                chk("line_o", line_o, mexp);
                chk("address_o_done", address_o, mt.addr);
                chk("strobes_in_done", {read_o, write_o}, 0);
                chk("error_o", error_o, mt.err);
                chk("beats_accepted", acc, mt.err ? 0 : 4);
                chk("strobe_cycles", strobe_cyc, cyc - mt.req_cyc - 1);
                if (mt.lat >= 0) chk("latency", cyc - mt.req_cyc, mt.lat);
                last_line = mexp;
            end
            rd_beats.delete();
            acc = 0;
            strobe_cyc = 0;
        end
    end

    task automatic issue(input bit rd, input bit wr, input logic [31:0] a, input logic [LW-1:0] l,
                         input int lat, input bit err);
        txn_t t;
        read_i = rd;
        write_i = wr;
        address_i = a;
        line_i = l;
        t.is_wr = wr;
        t.addr = a & 32'hFFFF_FFE0;
        t.line = l;
        t.lat = lat;
        t.err = err;
        t.req_cyc = cyc;
        q.push_back(t);
    endtask

    task automatic do_txn(input bit rd, input bit wr, input logic [31:0] a, input logic [LW-1:0] l,
                          input int lat, input bit err);
        @(negedge clk);
        issue(rd, wr, a, l, lat, err);
        @(negedge clk);
        read_i = 1'b0;
        write_i = 1'b0;
        address_i = $urandom;
        line_i = rnd_line();
        for (int i = 0; i < 300 && !resp_o; i++) @(negedge clk);
        if (!resp_o) chk("resp_o_wait_expired", 0, 1);
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_line_o", line_o, 0);
        chk("rst_address_o", address_o, 0);
        chk("rst_burst_o", burst_o, 0);
        chk("rst_strobes", {read_o, write_o, resp_o, error_o}, 0);
        rst = 1'b0;

        set_pat(16'hF, 4);
        beat_pat.push_back(64'hA0);
        beat_pat.push_back(64'hA1);
        beat_pat.push_back(64'hA2);
        beat_pat.push_back(64'hA3);
        do_txn(1, 0, 32'h0000_1234, '0, 5, 0);
        chk("read_line_const", line_o, {64'hA3, 64'hA2, 64'hA1, 64'hA0});
        chk("read_addr_const", address_o, 32'h0000_1220);

        set_pat(16'b1001101, 7);
        do_txn(0, 1, 32'h0000_2000, {64'hD3, 64'hD2, 64'hD1, 64'hD0}, 8, 0);
        chk("write_o_after", write_o, 0);

        do_txn(1, 1, 32'h0000_3008, rnd_line(), -1, 0);

        idle_resp = 1'b1;
        repeat (3) @(negedge clk);
        set_pat(16'hF, 4);
        beat_pat.push_back(64'hC0);
        beat_pat.push_back(64'hC1);
        beat_pat.push_back(64'hC2);
        beat_pat.push_back(64'hC3);
        do_txn(1, 0, 32'h0000_0100, '0, 5, 0);
        idle_resp = 1'b0;
        chk("spurious_beat0", line_o[63:0], 64'hC0);

        set_pat(16'b110, 3);
        beat_pat.push_back(64'hB0);
        beat_pat.push_back(64'hB1);
        @(negedge clk);
        issue(1, 0, 32'h0000_4444, '0, -1, 0);
        @(negedge clk);
        read_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("partial_beats", line_o[127:0], {64'hB1, 64'hB0});
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_read_o", read_o, 0);
        chk("rst_mid_line_o", line_o, 0);
        chk("rst_mid_resp_o", resp_o, 0);
        @(negedge clk);
        chk("rst_mid_resp_o_hold", resp_o, 0);
        rst = 1'b0;
        q.delete();
        rd_beats.delete();
        resp_pat.delete();
        beat_pat.delete();
        acc = 0;
        strobe_cyc = 0;
        last_line = '0;
        do_txn(1, 0, $urandom, '0, -1, 0);

        for (int n = 0; n < 24; n++) begin
            int k;
            k = $urandom_range(2);
            do_txn(k != 1, k != 0, $urandom, rnd_line(), -1, 0);
        end

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
        set_pat(16'h0, 12);
        do_txn(1, 0, 32'h0000_5000, '0, 9, 1);
        resp_pat.delete();
        do_txn(0, 1, 32'h0000_6000, rnd_line(), -1, 0);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
